// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus request/response types plus the arbiter's index width and state codes.
package cbus_rr_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } cbus_size_t;

  // Burst length is encoded as beat count minus one.
  typedef enum logic [3:0] {
    MLEN1  = 4'b0000,
    MLEN2  = 4'b0001,
    MLEN4  = 4'b0011,
    MLEN8  = 4'b0111,
    MLEN16 = 4'b1111
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam int NUM_REQ_DEF = 3;
  localparam int IDX_W       = $clog2(NUM_REQ_DEF);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Round-robin picker: first valid index strictly after last_grant, wrapping to the lowest valid.
module rr_pick #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] last_grant_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [N-1:0] masked;
  logic [N-1:0] cand;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = valid_i[i] && (W'(i) > last_grant_i);
    end
    cand  = (|masked) ? masked : valid_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) idx_o = W'(i);
    end
    any_o = |valid_i;
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin cbus arbiter: grants one requester at a time and holds the grant until the final beat.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cbus_req_t                  ireqs  [NUM_REQ],
  output cbus_resp_t                 iresps [NUM_REQ],
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 oresp,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       timeout
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [NUM_REQ-1:0] req_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_valid[i] = ireqs[i].valid;
  end

  rr_pick #(
    .N(NUM_REQ),
    .W(SEL_W)
  ) u_pick (
    .valid_i     (req_valid),
    .last_grant_i(last_q),
    .idx_o       (pick_idx),
    .any_o       (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(TIMEOUT)) timeout_d = 1'b1;
        // Release only on the final beat; a mid-burst valid drop keeps the lock.
        if (oresp.ready && oresp.last) begin
          state_d = IDLE;
          last_d  = sel_q;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= SEL_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) iresps[i] = '0;
    if (state_q == BUSY) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (SEL_W'(i) == sel_q) begin
          oreq      = ireqs[i];
          iresps[i] = oresp;
        end
      end
    end
  end

  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = sel_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: a transaction-level owner/pointer model checked every cycle plus directed literals.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 1024;

  logic             clk = 1'b0;
  logic             reset;
  cbus_req_t        ireqs  [N];
  cbus_resp_t       iresps [N];
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             timeout;

  int errors = 0;
  int checks = 0;

  cbus_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ireqs      (ireqs),
    .iresps     (iresps),
    .oreq       (oreq),
    .oresp      (oresp),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: who owns the bus, who owned it last, when the grant happened.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cyc   = 0;
  int m_gcyc  = 0;
  bit m_tmo   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1;
      m_last  = N - 1;
      m_cyc   = 0;
      m_gcyc  = 0;
      m_tmo   = 1'b0;
    end else begin
      m_cyc++;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && ireqs[(m_last + k) % N].valid) begin
            m_owner = (m_last + k) % N;
            m_gcyc  = m_cyc;
          end
        end
      end else begin
        if (m_cyc - m_gcyc >= TMO) m_tmo = 1'b1;
        if (oresp.ready && oresp.last) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  cbus_req_t  e_req;
  cbus_resp_t e_resp;
  always @(negedge clk) begin
    if (!reset) begin
      e_req = '0;
      if (m_owner >= 0) e_req = ireqs[m_owner];
      check("model oreq", 128'(oreq), 128'(e_req));
      for (int i = 0; i < N; i++) begin
        e_resp = (i == m_owner) ? oresp : '0;
        check($sformatf("model iresps[%0d]", i), 128'(iresps[i]), 128'(e_resp));
      end
      check("model grant_valid", 128'(grant_valid), 128'(m_owner >= 0));
      if (m_owner >= 0) check("model grant_idx", 128'(grant_idx), 128'(m_owner));
      check("model timeout", 128'(timeout), 128'(m_tmo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    oresp = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic beat(input logic last, input logic [31:0] data);
    oresp.ready = 1'b1;
    oresp.last  = last;
    oresp.data  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  int exp3 [6] = '{0, 1, 2, 0, 1, 2};
  int prev;
  logic [31:0] pat;

  initial begin
    // Reset state
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst grant_valid", 128'(grant_valid), 128'(0));
    check("rst grant_idx", 128'(grant_idx), 128'(0));
    check("rst timeout", 128'(timeout), 128'(0));
    check("rst oreq", 128'(oreq), 128'(0));
    for (int i = 0; i < N; i++) check($sformatf("rst iresps[%0d]", i), 128'(iresps[i]), 128'(0));
    reset = 1'b0;

    // Test 1: requester 1, 4-beat read
    ireqs[1].valid = 1'b1;
    ireqs[1].size  = MSIZE4;
    ireqs[1].addr  = 32'h1fc0_0000;
    ireqs[1].len   = MLEN4;
    #1;
    check("t1 oreq.valid before grant", 128'(oreq.valid), 128'(0));
    tick();
    check("t1 grant_valid", 128'(grant_valid), 128'(1));
    check("t1 grant_idx", 128'(grant_idx), 128'(1));
    check("t1 oreq.valid", 128'(oreq.valid), 128'(1));
    check("t1 oreq.addr", 128'(oreq.addr), 128'(32'h1fc0_0000));
    for (int b = 0; b < 4; b++) begin
      beat(b == 3, 32'hd000_0000 + 32'(b));
      #1;
      check("t1 iresps[1].ready", 128'(iresps[1].ready), 128'(1));
      check("t1 iresps[1].last", 128'(iresps[1].last), 128'(b == 3));
      check("t1 iresps[1].data", 128'(iresps[1].data), 128'(32'hd000_0000 + 32'(b)));
      tick();
    end
    ireqs[1].valid = 1'b0;
    oresp = '0;
    check("t1 released", 128'(grant_valid), 128'(0));

    // Test 2: simultaneous 0 and 2 after reset
    do_reset();
    ireqs[0].valid = 1'b1;
    ireqs[0].addr  = 32'h0000_1000;
    ireqs[2].valid = 1'b1;
    ireqs[2].addr  = 32'h0000_2000;
    tick();
    check("t2 first grant", 128'(grant_idx), 128'(0));
    check("t2 first addr", 128'(oreq.addr), 128'(32'h0000_1000));
    beat(1'b1, 32'h11);
    tick();
    ireqs[0].valid = 1'b0;
    oresp = '0;
    check("t2 idle gap", 128'(grant_valid), 128'(0));
    tick();
    check("t2 second valid", 128'(grant_valid), 128'(1));
    check("t2 second grant", 128'(grant_idx), 128'(2));
    beat(1'b1, 32'h22);
    tick();
    ireqs[2].valid = 1'b0;
    oresp = '0;

    // Test 3: all three continuously, single beats
    for (int i = 0; i < N; i++) begin
      ireqs[i].valid = 1'b1;
      ireqs[i].len   = MLEN1;
      ireqs[i].addr  = 32'h100 * 32'(i + 1);
    end
    prev = -1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check($sformatf("t3 rotation %0d", t), 128'(grant_idx), 128'(exp3[t]));
      if (prev >= 0) ireqs[prev].valid = 1'b1;
      beat(1'b1, 32'(t));
      tick();
      ireqs[exp3[t]].valid = 1'b0;
      oresp = '0;
      prev = exp3[t];
    end
    clear_inputs();

    // Test 4: owner 2 8-beat write burst while 0 waits
    ireqs[2].valid    = 1'b1;
    ireqs[2].is_write = 1'b1;
    ireqs[2].len      = MLEN8;
    ireqs[2].addr     = 32'h8000_0040;
    tick();
    check("t4 grant 2", 128'(grant_idx), 128'(2));
    ireqs[0].valid = 1'b1;
    ireqs[0].addr  = 32'h0000_3000;
    for (int b = 0; b < 8; b++) begin
      pat = 32'ha5a5_0000 ^ (32'(b) * 32'h1111);
      ireqs[2].data   = pat;
      ireqs[2].strobe = 4'b0001 << (b % 4);
      beat(b == 7, 32'h0);
      #1;
      check("t4 oreq.data", 128'(oreq.data), 128'(pat));
      check("t4 owner held", 128'(grant_idx), 128'(2));
      tick();
    end
    ireqs[2].valid = 1'b0;
    oresp = '0;
    check("t4 idle gap", 128'(grant_valid), 128'(0));
    tick();
    check("t4 grant 0 after", 128'(grant_idx), 128'(0));
    beat(1'b1, 32'h33);
    tick();
    clear_inputs();

    // Test 5: timeout, mid-burst valid drop, async reset
    ireqs[1].valid = 1'b1;
    ireqs[1].addr  = 32'h0000_4000;
    tick();
    check("t5 grant", 128'(grant_idx), 128'(1));
    for (int k = 1; k < TMO; k++) begin
      tick();
      if (k == 5) begin
        ireqs[1].valid = 1'b0;
        #1;
        check("t5 oreq.valid follows owner", 128'(oreq.valid), 128'(0));
        check("t5 grant held on drop", 128'(grant_valid), 128'(1));
      end
      if (k == 6) ireqs[1].valid = 1'b1;
    end
    check("t5 timeout not yet", 128'(timeout), 128'(0));
    tick();
    check("t5 timeout set", 128'(timeout), 128'(1));
    beat(1'b0, 32'hbeef);
    tick();
    check("t5 timeout sticky", 128'(timeout), 128'(1));
    check("t5 iresps before reset", 128'(iresps[1].ready), 128'(1));
    #3;
    reset = 1'b1;
    #1;
    check("t5 async grant_valid", 128'(grant_valid), 128'(0));
    check("t5 async timeout", 128'(timeout), 128'(0));
    check("t5 async oreq", 128'(oreq), 128'(0));
    check("t5 async iresps[1]", 128'(iresps[1]), 128'(0));
    clear_inputs();
    tick();
    reset = 1'b0;

    // Test 6: stray ready/last while idle
    beat(1'b1, 32'hdead);
    tick();
    tick();
    check("t6 still idle", 128'(grant_valid), 128'(0));
    for (int i = 0; i < N; i++) check($sformatf("t6 iresps[%0d]", i), 128'(iresps[i]), 128'(0));
    oresp = '0;
    ireqs[0].valid = 1'b1;
    tick();
    check("t6 grant after idle", 128'(grant_idx), 128'(0));
    beat(1'b1, 32'h44);
    tick();
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
